// File: rtl/nios_system_key_in_pkg.sv
// rtl/nios_system_key_in_pkg.sv - shared register offsets and edge-type encodings for the PIO slaves
package nios_system_key_in_pkg;

   // Word offsets inside a PIO slave; DATA/MASK/EDGE line up with the LEDR PIO map.
   typedef enum logic [1:0] {
      ADDR_DATA = 2'd0,
      ADDR_RSVD = 2'd1,
      ADDR_MASK = 2'd2,
      ADDR_EDGE = 2'd3
   } reg_addr_e;

   // Which transition of the synchronized input sets an edge-capture bit.
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_system_sync_bus.sv
// rtl/nios_system_sync_bus.sv - per-bit multi-flop synchronizer for an asynchronous input bus
module nios_system_sync_bus #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // stage[0] is the metastable catcher, stage[SYNC_STAGES-1] feeds the clk domain
   logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;

   // shift the raw input through the chain; cleared immediately on reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage <= '0;
      end else begin
         stage <= {stage[SYNC_STAGES-2:0], d};
      end
   end

   assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/nios_system_key_in.sv
// rtl/nios_system_key_in.sv - Avalon-MM input PIO with per-bit edge capture and level irq
module nios_system_key_in
   import nios_system_key_in_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = 1,
   parameter int IRQ_RESET   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   // Edge detection stays off until the chain and prev hold real samples,
   // so keys idling high at reset release do not look like edges.
   localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] det;
   logic [WIDTH-1:0] clr;
   logic [2:0]       arm_cnt;
   logic             armed;
   logic             wr_en;
   logic             unused_wdata;

   // writedata bits above WIDTH carry no meaning for this slave
   assign unused_wdata = ^writedata;

   nios_system_sync_bus #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (in_port),
      .q       (sync_q)
   );

   assign wr_en = chipselect && !write_n;
   assign armed = (arm_cnt == ARM_MAX);
   assign rise  = sync_q & ~prev;
   assign fall  = ~sync_q & prev;
   assign clr   = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

   // pick which transition counts as an edge for this instance
   always_comb begin
      det = '0;
      case (EDGE_TYPE)
         EDGE_RISE: det = rise;
         EDGE_FALL: det = fall;
         default:   det = rise | fall;
      endcase
   end

   // previous-sample register and arming counter that saturates once armed
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev    <= '0;
         arm_cnt <= '0;
      end else begin
         prev <= sync_q;
         if (arm_cnt != ARM_MAX) begin
            arm_cnt <= arm_cnt + 3'd1;
         end
      end
   end

   // mask register: plain read/write at offset 2
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= WIDTH'(IRQ_RESET);
      end else if (wr_en && address == ADDR_MASK) begin
         irq_mask <= writedata[WIDTH-1:0];
      end
   end

   // edge capture: a fresh detect beats a same-cycle write-one-to-clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_cap <= '0;
      end else begin
         edge_cap <= (det & {WIDTH{armed}}) | (edge_cap & ~clr);
      end
   end

   // registered level interrupt from any captured, unmasked edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq <= 1'b0;
      end else begin
         irq <= |(edge_cap & irq_mask);
      end
   end

   // zero-latency read mux; drives 0 when deselected so the interconnect can OR slaves
   always_comb begin
      readdata = '0;
      if (chipselect) begin
         case (reg_addr_e'(address))
            ADDR_DATA: readdata[WIDTH-1:0] = sync_q;
            ADDR_MASK: readdata[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: readdata[WIDTH-1:0] = edge_cap;
            default:   readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_nios_system_key_in.sv
// tb/tb_nios_system_key_in.sv - self-checking bench for the key/switch input PIO
module tb_nios_system_key_in;
   import nios_system_key_in_pkg::*;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [3:0]  in_port;
   logic        irq;

   nios_system_key_in #(
      .WIDTH       (4),
      .SYNC_STAGES (2),
      .EDGE_TYPE   (1),
      .IRQ_RESET   (0)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   typedef struct {
      logic        cs;
      logic [1:0]  addr;
      logic [31:0] exp;
      string       name;
   } vec_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_val(input string name, input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   task automatic compare_next(input logic [31:0] actual);
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got 0x%08h with no expectation queued", actual);
      end else begin
         e = sb.pop_front();
         if (actual !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, actual, e.exp);
         end
      end
   endtask

   task automatic bus_read(input logic cs, input logic [1:0] addr, input logic [31:0] exp,
                           input string name);
      expect_val(name, exp);
      chipselect = cs;
      write_n    = 1'b1;
      address    = addr;
      #1;
      compare_next(readdata);
      chipselect = 1'b0;
   endtask

   task automatic check_irq(input logic exp, input string name);
      expect_val(name, {31'd0, exp});
      compare_next({31'd0, irq});
   endtask

   task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = addr;
      writedata  = data;
      tick(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   vec_t vecs[6];

   initial begin
      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = '0;
      writedata  = '0;
      in_port    = 4'hF;

      // 1: keys idle high through reset and release
      tick(3);
      check_irq(1'b0, "reset_irq");
      bus_read(1'b1, ADDR_DATA, 32'h0, "reset_data");
      bus_read(1'b1, ADDR_MASK, 32'h0, "reset_mask");
      reset_n = 1'b1;
      tick(1);
      bus_read(1'b1, ADDR_DATA, 32'h0, "data_after_1");
      tick(1);
      bus_read(1'b1, ADDR_DATA, 32'hF, "data_after_2");
      bus_read(1'b0, ADDR_DATA, 32'h0, "deselected_zero");
      tick(5);
      bus_read(1'b1, ADDR_EDGE, 32'h0, "no_spurious_edge");
      check_irq(1'b0, "no_spurious_irq");

      // 2: falling edge bit0 with mask bit0
      bus_write(ADDR_MASK, 32'h1);
      in_port = 4'hE;
      tick(2);
      bus_read(1'b1, ADDR_EDGE, 32'h0, "edge_not_yet");
      check_irq(1'b0, "irq_not_yet");
      tick(1);
      bus_read(1'b1, ADDR_EDGE, 32'h1, "edge_at_3");
      check_irq(1'b0, "irq_not_at_3");
      tick(1);
      check_irq(1'b1, "irq_at_4");
      bus_write(ADDR_EDGE, 32'h1);
      bus_read(1'b1, ADDR_EDGE, 32'h0, "edge_cleared");
      check_irq(1'b1, "irq_still_on_clear_edge");
      tick(1);
      check_irq(1'b0, "irq_off_after_clear");

      // 3: masked edge captured, irq only once the mask opens
      bus_write(ADDR_MASK, 32'h0);
      in_port = 4'hA;
      tick(3);
      bus_read(1'b1, ADDR_EDGE, 32'h4, "masked_edge_captured");
      tick(2);
      check_irq(1'b0, "masked_no_irq");
      bus_write(ADDR_MASK, 32'h4);
      check_irq(1'b0, "irq_on_mask_edge");
      tick(1);
      check_irq(1'b1, "irq_after_unmask");

      // 4: W1C on bit1 in the same cycle as a new bit1 fall
      bus_write(ADDR_MASK, 32'h6);
      in_port = 4'h8;
      tick(3);
      bus_read(1'b1, ADDR_EDGE, 32'h6, "bit1_captured");
      in_port = 4'hA;
      tick(4);
      bus_write(ADDR_EDGE, 32'h4);
      bus_write(ADDR_MASK, 32'h2);
      bus_read(1'b1, ADDR_EDGE, 32'h2, "bit1_only");
      in_port = 4'h8;
      tick(2);
      bus_write(ADDR_EDGE, 32'h2);
      bus_read(1'b1, ADDR_EDGE, 32'h2, "detect_beats_clear");
      tick(1);
      check_irq(1'b1, "irq_held_1");
      tick(2);
      check_irq(1'b1, "irq_held_2");

      // 5: partial W1C and ignored writes to read-only offsets
      in_port = 4'hF;
      tick(4);
      in_port = 4'h8;
      tick(3);
      bus_read(1'b1, ADDR_EDGE, 32'h7, "edge_0x7");
      bus_write(ADDR_EDGE, 32'h5);
      bus_write(ADDR_DATA, 32'hFFFF_FFFF);
      bus_write(ADDR_RSVD, 32'hFFFF_FFFF);
      vecs[0] = '{1'b1, ADDR_EDGE, 32'h2, "w1c_partial"};
      vecs[1] = '{1'b1, ADDR_DATA, 32'h8, "data_unchanged"};
      vecs[2] = '{1'b1, ADDR_RSVD, 32'h0, "rsvd_reads_zero"};
      vecs[3] = '{1'b1, ADDR_MASK, 32'h2, "mask_unchanged"};
      vecs[4] = '{1'b0, ADDR_EDGE, 32'h0, "deselected_edge"};
      vecs[5] = '{1'b0, ADDR_MASK, 32'h0, "deselected_mask"};
      for (int i = 0; i < 6; i++) begin
         bus_read(vecs[i].cs, vecs[i].addr, vecs[i].exp, vecs[i].name);
      end

      // 6: reset asserted mid-capture
      bus_write(ADDR_MASK, 32'hF);
      in_port = 4'hF;
      tick(4);
      in_port = 4'h0;
      tick(4);
      bus_read(1'b1, ADDR_EDGE, 32'hF, "edge_all");
      check_irq(1'b1, "irq_all");
      reset_n = 1'b0;
      #1;
      check_irq(1'b0, "reset_clears_irq");
      bus_read(1'b1, ADDR_EDGE, 32'h0, "reset_clears_edge");
      bus_read(1'b1, ADDR_MASK, 32'h0, "reset_mask_default");
      tick(2);
      reset_n = 1'b1;
      tick(6);
      bus_read(1'b1, ADDR_EDGE, 32'h0, "rearm_no_edge");
      check_irq(1'b0, "rearm_no_irq");

      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
